// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light controller and its monitor:
// light bit positions, phase codes and the legal phase successor.
package traffic_pkg;

  localparam int RED_B = 2;
  localparam int YEL_B = 1;
  localparam int GRN_B = 0;

  localparam logic [1:0] PH_NONE   = 2'd0;
  localparam logic [1:0] PH_RED    = 2'd1;
  localparam logic [1:0] PH_GREEN  = 2'd2;
  localparam logic [1:0] PH_YELLOW = 2'd3;

  // State encoding matches the phase codes so a state maps directly to a phase.
  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_RED    = 2'd1,
    ST_GREEN  = 2'd2,
    ST_YELLOW = 2'd3
  } state_t;

  function automatic logic [1:0] next_phase(input logic [1:0] p);
    case (p)
      PH_RED:    return PH_GREEN;
      PH_GREEN:  return PH_YELLOW;
      PH_YELLOW: return PH_RED;
      default:   return PH_NONE;
    endcase
  endfunction

  // Any code that is not exactly one-hot decodes to PH_NONE.
  function automatic logic [1:0] decode_lights(input logic [2:0] l);
    if (l == 3'(1 << RED_B))      return PH_RED;
    else if (l == 3'(1 << GRN_B)) return PH_GREEN;
    else if (l == 3'(1 << YEL_B)) return PH_YELLOW;
    else                          return PH_NONE;
  endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Light bus plus the monitor's status/error outputs; the controller side
// (master) drives lights, the monitor (slave) drives everything else.
interface traffic_light_monitor_if #(
  parameter int CNT_W = 8,
  parameter int ERR_W = 8
);
  logic [2:0]       lights;
  logic [1:0]       phase;
  logic [CNT_W-1:0] dwell;
  logic             err_code;
  logic             err_seq;
  logic             err_short;
  logic             err_long;
  logic             err_any;
  logic [ERR_W-1:0] err_count;

  modport master (
    output lights,
    input  phase, dwell, err_code, err_seq, err_short, err_long, err_any, err_count
  );

  modport slave (
    input  lights,
    output phase, dwell, err_code, err_seq, err_short, err_long, err_any, err_count
  );
endinterface

// File: rtl/traffic_light_monitor_dwell_timer.sv
// Saturating dwell counter with load-1, plus MIN/MAX compare against the
// limits of the currently selected phase.
module tlm_dwell_timer
  import traffic_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int RED_MIN    = 4,
  parameter int RED_MAX    = 20,
  parameter int GREEN_MIN  = 4,
  parameter int GREEN_MAX  = 20,
  parameter int YELLOW_MIN = 2,
  parameter int YELLOW_MAX = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             inc,
  input  logic [1:0]       sel,
  output logic [CNT_W-1:0] dwell,
  output logic             short_flag,
  output logic             long_flag
);

  logic [CNT_W-1:0] dwell_reg;
  logic [CNT_W-1:0] min_v;
  logic [CNT_W-1:0] max_v;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      dwell_reg <= '0;
    end else if (load) begin
      dwell_reg <= CNT_W'(1);
    end else if (inc && (dwell_reg != {CNT_W{1'b1}})) begin
      dwell_reg <= dwell_reg + CNT_W'(1);
    end
  end

  always_comb begin
    min_v = '0;
    max_v = '0;
    case (sel)
      PH_RED:    begin min_v = CNT_W'(RED_MIN);    max_v = CNT_W'(RED_MAX);    end
      PH_GREEN:  begin min_v = CNT_W'(GREEN_MIN);  max_v = CNT_W'(GREEN_MAX);  end
      PH_YELLOW: begin min_v = CNT_W'(YELLOW_MIN); max_v = CNT_W'(YELLOW_MAX); end
      default:   begin min_v = '0;                 max_v = '0;                 end
    endcase
  end

  // long_flag means one more cycle in this phase would exceed MAX.
  assign short_flag = (sel != PH_NONE) && (dwell_reg < min_v);
  assign long_flag  = (sel != PH_NONE) && (dwell_reg == max_v);
  assign dwell      = dwell_reg;

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker on the controller's lights: decodes the phase, times each
// dwell and reports illegal codes, bad ordering and short/long phases.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int ERR_W      = 8,
  parameter int RED_MIN    = 4,
  parameter int RED_MAX    = 20,
  parameter int GREEN_MIN  = 4,
  parameter int GREEN_MAX  = 20,
  parameter int YELLOW_MIN = 2,
  parameter int YELLOW_MAX = 6
) (
  input logic clk,
  input logic rst,
  traffic_light_monitor_if.slave mon
);

  logic [2:0]       lights_reg;
  logic             sample_vld_reg;
  state_t           state_reg;
  logic [1:0]       phase_reg;
  logic             partial_reg;
  logic             err_code_reg, err_seq_reg, err_short_reg, err_long_reg;
  logic             err_any_reg;
  logic [ERR_W-1:0] err_count_reg;

  logic [1:0]       code;
  logic             onehot;
  logic             t_clr, t_load, t_inc;
  logic             short_flag, long_flag;
  logic [CNT_W-1:0] dwell;
  logic             err_code_next, err_seq_next, err_short_next, err_long_next;
  logic [2:0]       pulse_cnt;
  logic [ERR_W:0]   count_sum;
  logic [ERR_W-1:0] err_count_next;

  // Input capture stage; sample_vld_reg keeps the reset-time value of lights
  // from being judged on the first edge after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      lights_reg     <= '0;
      sample_vld_reg <= 1'b0;
    end else begin
      lights_reg     <= mon.lights;
      sample_vld_reg <= 1'b1;
    end
  end

  assign code   = decode_lights(lights_reg);
  assign onehot = (code != PH_NONE);

  always_comb begin
    t_clr          = 1'b0;
    t_load         = 1'b0;
    t_inc          = 1'b0;
    err_code_next  = 1'b0;
    err_seq_next   = 1'b0;
    err_short_next = 1'b0;
    err_long_next  = 1'b0;
    if (sample_vld_reg) begin
      if (state_reg == ST_SYNC) begin
        t_load        = onehot;
        err_code_next = !onehot;
      end else if (!onehot) begin
        t_clr         = 1'b1;
        err_code_next = 1'b1;
      end else if (code == phase_reg) begin
        t_inc         = 1'b1;
        err_long_next = long_flag && !partial_reg;
      end else begin
        t_load         = 1'b1;
        err_seq_next   = (code != next_phase(phase_reg));
        err_short_next = short_flag && !partial_reg;
      end
    end
  end

  assign pulse_cnt = {2'b00, err_code_next} + {2'b00, err_seq_next}
                   + {2'b00, err_short_next} + {2'b00, err_long_next};
  assign count_sum = {1'b0, err_count_reg} + (ERR_W + 1)'(pulse_cnt);
  assign err_count_next = count_sum[ERR_W] ? {ERR_W{1'b1}} : count_sum[ERR_W-1:0];

  tlm_dwell_timer #(
    .CNT_W     (CNT_W),
    .RED_MIN   (RED_MIN),
    .RED_MAX   (RED_MAX),
    .GREEN_MIN (GREEN_MIN),
    .GREEN_MAX (GREEN_MAX),
    .YELLOW_MIN(YELLOW_MIN),
    .YELLOW_MAX(YELLOW_MAX)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr       (t_clr),
    .load      (t_load),
    .inc       (t_inc),
    .sel       (phase_reg),
    .dwell     (dwell),
    .short_flag(short_flag),
    .long_flag (long_flag)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_SYNC;
      phase_reg     <= PH_NONE;
      partial_reg   <= 1'b0;
      err_code_reg  <= 1'b0;
      err_seq_reg   <= 1'b0;
      err_short_reg <= 1'b0;
      err_long_reg  <= 1'b0;
      err_any_reg   <= 1'b0;
      err_count_reg <= '0;
    end else begin
      err_code_reg  <= err_code_next;
      err_seq_reg   <= err_seq_next;
      err_short_reg <= err_short_next;
      err_long_reg  <= err_long_next;
      err_count_reg <= err_count_next;
      err_any_reg   <= err_any_reg | (pulse_cnt != 3'd0);
      if (sample_vld_reg) begin
        case (state_reg)
          ST_SYNC: begin
            if (onehot) begin
              state_reg   <= state_t'(code);
              phase_reg   <= code;
              partial_reg <= 1'b1;
            end
          end
          default: begin
            if (!onehot) begin
              state_reg   <= ST_SYNC;
              phase_reg   <= PH_NONE;
              partial_reg <= 1'b0;
            end else if (code != phase_reg) begin
              // Enter the new phase even after a sequence error so checking resyncs.
              state_reg   <= state_t'(code);
              phase_reg   <= code;
              partial_reg <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  assign mon.phase     = phase_reg;
  assign mon.dwell     = dwell;
  assign mon.err_code  = err_code_reg;
  assign mon.err_seq   = err_seq_reg;
  assign mon.err_short = err_short_reg;
  assign mon.err_long  = err_long_reg;
  assign mon.err_any   = err_any_reg;
  assign mon.err_count = err_count_reg;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor: the driver pushes the expected
// outputs for each lights sample, a negedge monitor pops and compares them.
module tb_traffic_light_monitor;
  import traffic_pkg::*;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #1 clk = ~clk;

  traffic_light_monitor_if #(.CNT_W(8), .ERR_W(8)) bus ();

  traffic_light_monitor dut (
    .clk(clk),
    .rst(rst),
    .mon(bus)
  );

  typedef struct {
    int         due;
    logic [2:0] lights;
    logic [1:0] ph;
    logic [7:0] dw;
    logic [3:0] errs;   // {code, seq, short, long}
    logic [7:0] cnt;
    logic       any;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  // reference model state
  logic [1:0] m_ph;
  int         m_dw;
  logic       m_part;
  int         m_cnt;
  logic       m_any;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lim_min(input logic [1:0] p);
    case (p)
      2'd1: return 4;
      2'd2: return 4;
      2'd3: return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int lim_max(input logic [1:0] p);
    case (p)
      2'd1: return 20;
      2'd2: return 20;
      2'd3: return 6;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_ph = 2'd0; m_dw = 0; m_part = 1'b0; m_cnt = 0; m_any = 1'b0;
  endtask

  // Apply one sample per cycle; each sample's outputs appear two edges later.
  task automatic drive(input logic [2:0] l, input int n);
    for (int k = 0; k < n; k++) begin
      logic [1:0] c;
      logic ec, es, esh, el;
      exp_t e;
      bus.lights = l;
      ec = 1'b0; es = 1'b0; esh = 1'b0; el = 1'b0;
      case (l)
        3'b100:  c = 2'd1;
        3'b001:  c = 2'd2;
        3'b010:  c = 2'd3;
        default: c = 2'd0;
      endcase
      if (m_ph == 2'd0) begin
        if (c != 2'd0) begin m_ph = c; m_dw = 1; m_part = 1'b1; end
        else ec = 1'b1;
      end else if (c == 2'd0) begin
        ec = 1'b1; m_ph = 2'd0; m_dw = 0; m_part = 1'b0;
      end else if (c == m_ph) begin
        if (m_dw == lim_max(m_ph) && !m_part) el = 1'b1;
        if (m_dw < 255) m_dw++;
      end else begin
        es  = !((m_ph == 2'd1 && c == 2'd2) || (m_ph == 2'd2 && c == 2'd3) ||
                (m_ph == 2'd3 && c == 2'd1));
        esh = (m_dw < lim_min(m_ph)) && !m_part;
        m_ph = c; m_dw = 1; m_part = 1'b0;
      end
      m_cnt = m_cnt + int'(ec) + int'(es) + int'(esh) + int'(el);
      if (m_cnt > 255) m_cnt = 255;
      if (ec || es || esh || el) m_any = 1'b1;
      e.due = cyc + 2; e.lights = l; e.ph = m_ph; e.dw = 8'(m_dw);
      e.errs = {ec, es, esh, el}; e.cnt = 8'(m_cnt); e.any = m_any;
      q.push_back(e);
      @(negedge clk);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      logic [3:0] ge;
      e  = q.pop_front();
      ge = {bus.err_code, bus.err_seq, bus.err_short, bus.err_long};
      tests++;
      if (e.due != cyc || bus.phase != e.ph || bus.dwell != e.dw || ge != e.errs ||
          bus.err_count != e.cnt || bus.err_any != e.any) begin
        fails++;
        $display("FAIL sb cyc=%0d lights=%b: got ph=%0d dw=%0d errs=%b cnt=%0d any=%b, want ph=%0d dw=%0d errs=%b cnt=%0d any=%b",
                 cyc, e.lights, bus.phase, bus.dwell, ge, bus.err_count, bus.err_any,
                 e.ph, e.dw, e.errs, e.cnt, e.any);
      end else begin
        $display("[TB] cyc=%0d lights=%b ph=%0d dw=%0d errs=%b cnt=%0d any=%b ok",
                 cyc, e.lights, bus.phase, bus.dwell, ge, bus.err_count, bus.err_any);
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end else begin
      $display("[TB] %s = %0d ok", name, got);
    end
  endtask

  task automatic drain();
    int w = 0;
    while (q.size() != 0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d entries still queued, want 0", q.size());
      q.delete();
    end
  endtask

  task automatic do_reset();
    drain();
    rst = 1'b1;
    bus.lights = 3'b000;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("rst_phase", int'(bus.phase), 0);
    chk("rst_dwell", int'(bus.dwell), 0);
    chk("rst_errs", int'({bus.err_code, bus.err_seq, bus.err_short, bus.err_long}), 0);
    chk("rst_any", int'(bus.err_any), 0);
    chk("rst_count", int'(bus.err_count), 0);
  endtask

  initial begin
    bus.lights = 3'b000;
    model_reset();

    // clean cycle starting with a partial red
    do_reset();
    drive(R, 6); drive(G, 6); drive(Y, 3); drive(R, 6);
    drain();
    chk("s1_count", int'(bus.err_count), 0);
    chk("s1_phase", int'(bus.phase), int'(PH_RED));

    // partial short green is not an error
    do_reset();
    drive(G, 2); drive(Y, 3);
    drain();
    chk("s2_count", int'(bus.err_count), 0);
    chk("s2_phase", int'(bus.phase), int'(PH_YELLOW));

    // full-phase green of 2 cycles is short
    do_reset();
    drive(Y, 1); drive(R, 6); drive(G, 2); drive(Y, 3);
    drain();
    chk("s3_count", int'(bus.err_count), 1);
    chk("s3_any", int'(bus.err_any), 1);

    // green held 21 then longer: one err_long only
    do_reset();
    drive(Y, 1); drive(R, 4); drive(G, 21); drive(G, 3);
    drain();
    chk("s4_count", int'(bus.err_count), 1);

    // red -> yellow skips green
    do_reset();
    drive(Y, 1); drive(R, 6); drive(Y, 1);
    drain();
    chk("s5_count", int'(bus.err_count), 1);
    chk("s5_phase", int'(bus.phase), int'(PH_YELLOW));

    // simultaneous sequence and short errors
    do_reset();
    drive(Y, 1); drive(R, 2); drive(Y, 1);
    drain();
    chk("s6_count", int'(bus.err_count), 2);

    // boundaries: green 20 and yellow 2 legal, green 3 short, yellow 7 long
    do_reset();
    drive(Y, 1); drive(R, 4); drive(G, 20); drive(Y, 2); drive(R, 4);
    drive(G, 3); drive(Y, 7); drive(R, 1);
    drain();
    chk("s7_count", int'(bus.err_count), 2);

    // illegal codes mid-green, then resync on green, then reset clears
    do_reset();
    drive(Y, 1); drive(R, 4); drive(G, 3); drive(3'b011, 1); drive(3'b000, 1);
    drive(G, 1);
    drain();
    chk("s8_count", int'(bus.err_count), 2);
    chk("s8_any", int'(bus.err_any), 1);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
